// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries one payload between two pipeline stages with a valid/ready
// handshake, a synchronous flush for branch redirects, an optional
// 2-entry skid buffer (registered in_ready) and a saturating count of
// entries discarded by flush.
//
// Handshake: a transfer happens at a rising clk edge when valid and ready
// are both high on that side (in = in_valid & in_ready,
// out = out_valid & out_ready). While out_valid is high and out_ready is
// low, out_valid and out_data hold unchanged. in_ready does not depend on
// in_valid.
module pipe_stage_reg #(
    parameter int                    DATA_WIDTH  = 64,
    parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0,
    parameter int                    SKID        = 1,
    parameter int                    CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  kill_cnt
);

    // The state value is the number of live entries, so occupancy is the
    // state itself and doubles as the debug view of the FSM.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   main_q;
    logic [DATA_WIDTH-1:0]   skid_q;
    logic                    in_ready_q;
    logic [CNT_WIDTH-1:0]    kill_q;

    logic                    in_fire;
    logic                    out_fire;
    logic [1:0]              kill_inc;
    logic [CNT_WIDTH:0]      kill_sum;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = logic'(1'b0) ? 2'd0 : 2'(state_q);
    assign kill_cnt  = kill_q;

    // With the skid buffer in_ready comes straight from a flop; without it
    // the single register may reload in the same cycle it is drained.
    assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~out_valid);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Entries killed by a flush: everything held except one delivered now.
    assign kill_inc = 2'(state_q) - {1'b0, out_fire};
    assign kill_sum = {1'b0, kill_q} + {{(CNT_WIDTH-1){1'b0}}, kill_inc};

    // Entry storage, occupancy FSM, registered in_ready and kill counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            main_q     <= FLUSH_VALUE;
            skid_q     <= FLUSH_VALUE;
            in_ready_q <= 1'b1;
            kill_q     <= '0;
        end else if (flush) begin
            // A same-cycle input is dropped; a same-cycle output counts as
            // delivered and is excluded from kill_inc.
            state_q    <= EMPTY;
            main_q     <= FLUSH_VALUE;
            in_ready_q <= 1'b1;
            kill_q     <= kill_sum[CNT_WIDTH] ? '1 : kill_sum[CNT_WIDTH-1:0];
        end else if (SKID == 0) begin
            in_ready_q <= 1'b1;
            if (in_fire) begin
                main_q  <= in_data;
                state_q <= MAIN;
            end else if (out_fire) begin
                state_q <= EMPTY;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_q  <= in_data;
                        state_q <= MAIN;
                    end
                    in_ready_q <= 1'b1;
                end
                MAIN: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            // Head is stalled: park the new entry behind it.
                            skid_q     <= in_data;
                            state_q    <= FULL;
                            in_ready_q <= 1'b0;
                        end
                        2'b11: begin
                            main_q     <= in_data;
                            in_ready_q <= 1'b1;
                        end
                        2'b01: begin
                            // main_q keeps the delivered value as a bubble.
                            state_q    <= EMPTY;
                            in_ready_q <= 1'b1;
                        end
                        default: in_ready_q <= 1'b1;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state_q    <= MAIN;
                        in_ready_q <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three copies of pipe_stage_reg driven by the same
// stimulus: skid buffer with 16-bit counter, skid buffer with 2-bit
// counter, and single-entry register. Each is compared every cycle against
// a queue-based model of an in-order buffer of capacity 2 or 1.
module tb_pipe_stage_reg;

    localparam logic [63:0] FV = 64'hDEAD_BEEF_CAFE_0001;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_data;

    logic        ir  [3];
    logic        ov  [3];
    logic [63:0] od  [3];
    logic [1:0]  occ [3];
    logic [15:0] kc0;
    logic [1:0]  kc1;
    logic [15:0] kc2;

    // Model state per instance: live entries in order, last value shown on
    // out_data when empty, and the kill count with its saturation limit.
    logic [63:0] exp_q [3][$];
    logic [63:0] last_v [3];
    int          kill_m [3];
    int          kill_max [3] = '{65535, 3, 65535};

    int n_cmp = 0;
    int n_err = 0;

    // clock
    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_WIDTH(64), .FLUSH_VALUE(FV), .SKID(1), .CNT_WIDTH(16)) u_skid (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .occupancy(occ[0]), .kill_cnt(kc0)
    );

    pipe_stage_reg #(.DATA_WIDTH(64), .FLUSH_VALUE(FV), .SKID(1), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .occupancy(occ[1]), .kill_cnt(kc1)
    );

    pipe_stage_reg #(.DATA_WIDTH(64), .FLUSH_VALUE(FV), .SKID(0), .CNT_WIDTH(16)) u_flop (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
        .occupancy(occ[2]), .kill_cnt(kc2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready(input int m);
        if (m == 2) return out_ready || (exp_q[m].size() == 0);
        return exp_q[m].size() < 2;
    endfunction

    function automatic logic [63:0] kill_obs(input int m);
        if (m == 0) return {48'd0, kc0};
        if (m == 1) return {62'd0, kc1};
        return {48'd0, kc2};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            exp_q[m].delete();
            last_v[m] = FV;
            kill_m[m] = 0;
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare all outputs
    // to the model, advance the model, then cross the rising edge.
    task automatic step(input logic iv, input logic [63:0] d, input logic ordy,
                        input logic fl, input logic rn);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset_n   = rn;
        #1;
        for (int m = 0; m < 3; m++) begin
            logic        vld;
            logic        rdy;
            logic [63:0] head;
            vld  = exp_q[m].size() > 0;
            rdy  = model_ready(m);
            head = vld ? exp_q[m][0] : last_v[m];
            check_eq($sformatf("i%0d out_valid", m), {63'd0, ov[m]}, {63'd0, vld});
            check_eq($sformatf("i%0d out_data", m), od[m], head);
            check_eq($sformatf("i%0d in_ready", m), {63'd0, ir[m]}, {63'd0, rdy});
            check_eq($sformatf("i%0d occupancy", m), {62'd0, occ[m]}, 64'(exp_q[m].size()));
            check_eq($sformatf("i%0d kill_cnt", m), kill_obs(m), 64'(kill_m[m]));
        end
        for (int m = 0; m < 3; m++) begin
            logic outf;
            logic inf;
            outf = (exp_q[m].size() > 0) && ordy;
            inf  = iv && model_ready(m);
            if (!rn) begin
                exp_q[m].delete();
                last_v[m] = FV;
                kill_m[m] = 0;
            end else if (fl) begin
                kill_m[m] = kill_m[m] + exp_q[m].size() - int'(outf);
                if (kill_m[m] > kill_max[m]) kill_m[m] = kill_max[m];
                exp_q[m].delete();
                last_v[m] = FV;
            end else begin
                if (outf) last_v[m] = exp_q[m].pop_front();
                if (inf) exp_q[m].push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Streaming with downstream always ready.
        for (int i = 1; i <= 4; i++) step(1'b1, 64'(i), 1'b1, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);

        // Backpressure: two entries, then a stalled third, then release.
        step(1'b1, 64'h10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'h20, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 64'h30, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 64'h30, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);

        // Flush while full, with an input offered in the flush cycle.
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 64'hA1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hA2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hA3, 1'b0, 1'b1, 1'b1);
        check_eq("flush_full kill_cnt", {48'd0, kc0}, 64'd2);
        check_eq("flush_full out_data", od[0], FV);
        // Flush held over several cycles keeps the stage empty.
        step(1'b1, 64'hA4, 1'b1, 1'b1, 1'b1);
        step(1'b1, 64'hA5, 1'b1, 1'b1, 1'b1);
        check_eq("flush_held occupancy", {62'd0, occ[0]}, 64'd0);

        // Flush coinciding with a delivery kills nothing.
        step(1'b1, 64'hB1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 64'd0, 1'b1, 1'b1, 1'b1);
        check_eq("flush_out kill_cnt", {48'd0, kc0}, 64'd2);

        // Saturation of the 2-bit counter after four full flushes.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0, 1'b1);
            step(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0, 1'b1);
            step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1);
        end
        check_eq("sat kill_cnt", {62'd0, kc1}, 64'd3);

        // Reset in the middle of a stall drops entries uncounted.
        step(1'b1, 64'hE1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hE2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 64'hE3, 1'b0, 1'b0, 1'b0);
        check_eq("reset_stall kill_cnt", {48'd0, kc0}, 64'd0);
        check_eq("reset_stall out_valid", {63'd0, ov[0]}, 64'd0);

        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 800; i++) begin
            logic        iv;
            logic        ordy;
            logic        fl;
            logic        rn;
            logic [63:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 15) == 0);
            rn   = ($urandom_range(0, 63) != 0);
            d    = {$urandom, $urandom};
            step(iv, d, ordy, fl, rn);
        end
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
